pipe_issue_ctrl: RTL
====================

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: instr_valid  input  1  fetch presents a valid instruction this cycle.
REQ-004: instr  input  32  instruction; [25:21] dest, [20:16] src1, [15:11] src2, [29] immediate flag (1 = I-type).
REQ-005: flush  input  1  discard in-flight tracking and the current instruction.
REQ-006: issue_valid  output  1  instruction accepted this cycle; decode stage captures instr when high.
REQ-007: stall  output  1  fetch holds PC and instr this cycle.
REQ-008: ctrl_state  output  2  FSM state: 00 IDLE, 01 ISSUE, 10 STALL.
REQ-009: stall_count  output  16  saturating count of stall cycles since reset.

Function
REQ-010: Scoreboard SHALL be 3 entries {valid, dest[4:0]}: E0 = 1 cycle old, E1 = 2 cycles, E2 = 3 cycles.
REQ-011: Every clock edge: E2<=E1, E1<=E0, E0<={issue_valid, instr[25:21]}; a non-issuing cycle inserts an invalid bubble into E0.
REQ-012: src1 SHALL always be compared; src2 SHALL be compared only when instr[29]=0.
REQ-013: hazard SHALL be high when any checked valid entry's dest equals a compared source; register 0 is not special.
REQ-014: issue_valid = instr_valid & ~hazard & ~flush, combinational, zero latency.
REQ-015: stall = instr_valid & hazard & ~flush, combinational.
REQ-016: flush SHALL, at the next edge, invalidate E0..E2 and force ctrl_state to IDLE; flush wins over simultaneous instr_valid.
REQ-017: FSM next state: flush -> IDLE; else ~instr_valid -> IDLE; else hazard -> STALL; else ISSUE; ctrl_state shows the registered state of the previous cycle's decision.
REQ-018: stall_count increments by 1 on each edge where stall=1; holds at 16'hFFFF, no wrap.
REQ-019: Maximum consecutive stall for one instruction: 3 cycles (bypass disabled), 1 cycle (bypass enabled).
REQ-020: Back-to-back independent instructions SHALL issue every cycle with no bubble.

Reset
REQ-021: rst high SHALL asynchronously clear E0..E2 valid bits and dest fields, ctrl_state=IDLE, stall_count=0.
REQ-022: During rst, issue_valid and stall SHALL be 0 regardless of instr_valid.
REQ-023: Reset mid-stall SHALL abandon the hazard; first cycle after release sees an empty scoreboard.

Configuration
REQ-024: Macro PIPE_ISSUE_BYPASS_EN: when defined, hazard checks only E0 (E1/E2 results forwarded by datapath).
REQ-025: When PIPE_ISSUE_BYPASS_EN is undefined, hazard checks E0, E1 and E2.

Verification
REQ-026: Reset, then instr 32'h0041_0000 (r2<=r1) then 32'h0062_0000 (r3<=r2), bypass off -> second instr stall=1 for 3 cycles, issue_valid on 4th; stall_count=3.
REQ-027: Same sequence with PIPE_ISSUE_BYPASS_EN -> 1 stall cycle, issue on 2nd cycle; stall_count=1.
REQ-028: 32'h0041_0000 then I-type 32'h2085_1000 (src2 field = r2, ignored) -> no stall, both issue consecutively, ctrl_state ISSUE.
REQ-029: Stall in progress, assert flush one cycle -> issue_valid=0 that cycle, next cycle scoreboard empty, held instr issues immediately, ctrl_state IDLE then ISSUE.
REQ-030: Force stall_count to 16'hFFFE via 0xFFFE stall cycles, two more stalls -> stall_count=16'hFFFF, holds.
REQ-031: Assert rst asynchronously between edges during STALL -> outputs and stall_count clear before next edge; after release, 32'h0062_0000 issues without stall.

Source files
------------

// File: rtl/pipe_issue_ctrl_if.sv
// Issue-control bundle between fetch and the issue controller.
// master = fetch side (drives the instruction), slave = issue controller.
interface pipe_issue_ctrl_if;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;
  logic        issue_valid;
  logic        stall;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_count;

  modport master (
    output instr_valid, instr, flush,
    input  issue_valid, stall, ctrl_state, stall_count
  );

  modport slave (
    input  instr_valid, instr, flush,
    output issue_valid, stall, ctrl_state, stall_count
  );
endinterface

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller with a 3-deep age-shifted destination scoreboard.
// An instruction issues in the same cycle it is presented unless one of its
// source registers matches the destination of a recently issued instruction
// still tracked by the scoreboard; in that case fetch is stalled.
// Optional build macro: PIPE_ISSUE_BYPASS_EN -- when defined, only the
// youngest scoreboard entry (E0) is checked because the datapath forwards
// results held in E1/E2.
module pipe_issue_ctrl (
  input  logic              clk,
  input  logic              rst,
  pipe_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_STALL = 2'b10
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
  } sb_entry_t;

  localparam int SB_DEPTH = 3;
`ifdef PIPE_ISSUE_BYPASS_EN
  localparam int CHECK_DEPTH = 1;
`else
  localparam int CHECK_DEPTH = 3;
`endif

  // Scoreboard: index 0 = issued 1 cycle ago, index 2 = issued 3 cycles ago.
  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  state_e                   state_q, state_d;
  logic [15:0]              stall_count_q, stall_count_d;

  logic [4:0] dest;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       imm;
  logic       hazard;
  logic       issue;
  logic       stall;

  // Instruction field extraction.
  assign dest = bus.instr[25:21];
  assign src1 = bus.instr[20:16];
  assign src2 = bus.instr[15:11];
  assign imm  = bus.instr[29];

  // Bits of the instruction word and the oldest entry that the control
  // logic may not look at in every build; collected here on purpose.
  logic unused_bits;
  assign unused_bits = ^{bus.instr[31:30], bus.instr[28:26], bus.instr[10:0],
                         sb_q[SB_DEPTH-1]};

  // Hazard detection: src1 always compared, src2 only for R-type.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    hazard = 1'b0;
    for (int i = 0; i < CHECK_DEPTH; i++) begin
      if (sb_q[i].valid &&
          ((sb_q[i].dest == src1) || (!imm && (sb_q[i].dest == src2)))) begin
        hazard = 1'b1;
      end
    end
  end

  // Zero-latency handshake; both outputs are held low while in reset.
  assign issue = bus.instr_valid & ~hazard & ~bus.flush & ~rst;
  assign stall = bus.instr_valid &  hazard & ~bus.flush & ~rst;

  // Scoreboard shift: age every entry, insert this cycle's issue (or a bubble).
  always_comb begin
    sb_d = sb_q;
    if (bus.flush) begin
      sb_d = '0;
    end else begin
      for (int i = SB_DEPTH - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0].valid = issue;
      sb_d[0].dest  = dest;
    end
  end

  // FSM next state: records this cycle's decision for display next cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else if (!bus.instr_valid) begin
      state_d = ST_IDLE;
    end else if (hazard) begin
      state_d = ST_STALL;
    end else begin
      state_d = ST_ISSUE;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is only a few flops, so it is reset explicitly
      // (valid and dest) and the first cycle after reset sees it empty.
      sb_q          <= '0;
      state_q       <= ST_IDLE;
      stall_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values of the others.
      sb_q          <= sb_d;
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Output drive.
  assign bus.issue_valid = issue;
  assign bus.stall       = stall;
  assign bus.ctrl_state  = state_q;
  assign bus.stall_count = stall_count_q;

endmodule
